// File: rtl/string_scheduler.sv
// Sequences a text string into per-row glyph jobs: fetches each character, then issues GLYPH_H rows.
// Optional macro STRING_SCHED_CLIP_EN stops the string at the first glyph that would cross H_RES.
module string_scheduler #(
  parameter int unsigned GLYPH_H = 16,
  parameter int unsigned GLYPH_W = 8,
  parameter int unsigned H_RES   = 320,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned TXT_AW  = 12,
  parameter int unsigned LEN_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [TXT_AW-1:0]  cmd_base,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [3:0]         cmd_fg,
  input  logic [3:0]         cmd_bg,
  output logic               txt_rd_en,
  output logic [TXT_AW-1:0]  txt_addr,
  input  logic [7:0]         txt_rd_data,
  output logic               glyph_start,
  output logic [7:0]         glyph_char,
  output logic [3:0]         glyph_dy,
  output logic [3:0]         glyph_fg,
  output logic [3:0]         glyph_bg,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  input  logic               glyph_done,
  output logic               busy,
  output logic               cmd_done
);

  localparam int unsigned SumW    = COORD_W + LEN_W + 4;
  localparam logic [3:0]  LastRow = 4'(GLYPH_H - 1);
`ifdef STRING_SCHED_CLIP_EN
  localparam bit ClipEn = 1'b1;
`else
  localparam bit ClipEn = 1'b0;
`endif

  // StNext is the turnaround cycle after a row completes, where dy/idx advance.
  typedef enum logic [2:0] {
    StIdle, StFetch, StWaitRd, StIssue, StWaitDone, StNext, StFinish
  } state_e;

  state_e             state_q, state_d;
  logic [TXT_AW-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [3:0]         fg_q, fg_d, bg_q, bg_d, dy_q, dy_d;
  logic               txt_rd_en_q, txt_rd_en_d, glyph_start_q, glyph_start_d;
  logic               cmd_done_q, cmd_done_d;
  logic [TXT_AW-1:0]  txt_addr_q, txt_addr_d;
  logic [7:0]         glyph_char_q, glyph_char_d;
  logic [3:0]         glyph_dy_q, glyph_dy_d, glyph_fg_q, glyph_fg_d, glyph_bg_q, glyph_bg_d;
  logic [COORD_W-1:0] fb_x_q, fb_x_d, fb_y_q, fb_y_d;

  function automatic logic fits(input logic [COORD_W-1:0] x, input logic [LEN_W-1:0] idx);
    logic [SumW-1:0] right_edge;
    right_edge = SumW'(x) + SumW'(idx) * SumW'(GLYPH_W) + SumW'(GLYPH_W);
    return !ClipEn || (right_edge <= SumW'(H_RES));
  endfunction

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    x_d          = x_q;
    y_d          = y_q;
    fg_d         = fg_q;
    bg_d         = bg_q;
    idx_d        = idx_q;
    dy_d         = dy_q;
    txt_addr_d   = txt_addr_q;
    glyph_char_d = glyph_char_q;
    glyph_dy_d   = glyph_dy_q;
    glyph_fg_d   = glyph_fg_q;
    glyph_bg_d   = glyph_bg_q;
    fb_x_d       = fb_x_q;
    fb_y_d       = fb_y_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          base_d = cmd_base;
          len_d  = cmd_len;
          x_d    = cmd_x;
          y_d    = cmd_y;
          fg_d   = cmd_fg;
          bg_d   = cmd_bg;
          idx_d  = '0;
          dy_d   = '0;
          state_d = (cmd_len == '0 || !fits(cmd_x, '0)) ? StFinish : StFetch;
        end
      end
      StFetch:  state_d = StWaitRd;
      StWaitRd: begin
        glyph_char_d = txt_rd_data;
        state_d      = StIssue;
      end
      StIssue:  state_d = StWaitDone;
      StWaitDone: begin
        if (glyph_done) begin
          if (dy_q != LastRow) begin
            state_d = StNext;
          end else if (idx_q == len_q - LEN_W'(1) || !fits(x_q, idx_q + LEN_W'(1))) begin
            state_d = StFinish;
          end else begin
            state_d = StNext;
          end
        end
      end
      StNext: begin
        if (dy_q != LastRow) begin
          dy_d    = dy_q + 4'd1;
          state_d = StIssue;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          dy_d    = '0;
          state_d = StFetch;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    txt_rd_en_d   = (state_d == StFetch);
    glyph_start_d = (state_d == StIssue);
    cmd_done_d    = (state_d == StFinish);
    if (state_d == StFetch) txt_addr_d = base_d + TXT_AW'(idx_d);
    // Job descriptors change only when entering ISSUE, so they hold for the whole job.
    if (state_d == StIssue) begin
      glyph_dy_d = dy_d;
      glyph_fg_d = fg_q;
      glyph_bg_d = bg_q;
      fb_x_d     = COORD_W'(SumW'(x_q) + SumW'(idx_d) * SumW'(GLYPH_W));
      fb_y_d     = y_q + COORD_W'(dy_d);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      base_q        <= '0;
      len_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      fg_q          <= '0;
      bg_q          <= '0;
      idx_q         <= '0;
      dy_q          <= '0;
      txt_rd_en_q   <= 1'b0;
      glyph_start_q <= 1'b0;
      cmd_done_q    <= 1'b0;
      txt_addr_q    <= '0;
      glyph_char_q  <= '0;
      glyph_dy_q    <= '0;
      glyph_fg_q    <= '0;
      glyph_bg_q    <= '0;
      fb_x_q        <= '0;
      fb_y_q        <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      x_q           <= x_d;
      y_q           <= y_d;
      fg_q          <= fg_d;
      bg_q          <= bg_d;
      idx_q         <= idx_d;
      dy_q          <= dy_d;
      txt_rd_en_q   <= txt_rd_en_d;
      glyph_start_q <= glyph_start_d;
      cmd_done_q    <= cmd_done_d;
      txt_addr_q    <= txt_addr_d;
      glyph_char_q  <= glyph_char_d;
      glyph_dy_q    <= glyph_dy_d;
      glyph_fg_q    <= glyph_fg_d;
      glyph_bg_q    <= glyph_bg_d;
      fb_x_q        <= fb_x_d;
      fb_y_q        <= fb_y_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign cmd_done    = cmd_done_q;
  assign txt_rd_en   = txt_rd_en_q;
  assign txt_addr    = txt_addr_q;
  assign glyph_start = glyph_start_q;
  assign glyph_char  = glyph_char_q;
  assign glyph_dy    = glyph_dy_q;
  assign glyph_fg    = glyph_fg_q;
  assign glyph_bg    = glyph_bg_q;
  assign fb_x        = fb_x_q;
  assign fb_y        = fb_y_q;

endmodule

// File: tb/tb_string_scheduler.sv
// Scoreboard bench for string_scheduler: a string-level model queues expected reads, jobs and
// completions; independent monitor and glyph-unit processes check what the DUT produces.
module tb_string_scheduler;
  localparam int GH = 16, GW = 8, HRES = 320;
`ifdef STRING_SCHED_CLIP_EN
  localparam bit Clip = 1'b1;
`else
  localparam bit Clip = 1'b0;
`endif
  localparam logic [56:0] RstExp = {1'b1, 56'd0};

  logic clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, glyph_done = 1'b0;
  logic [11:0] cmd_base = '0;
  logic [7:0]  cmd_len = '0, txt_rd_data = '0;
  logic [9:0]  cmd_x = '0, cmd_y = '0;
  logic [3:0]  cmd_fg = '0, cmd_bg = '0;
  logic        cmd_ready, txt_rd_en, glyph_start, busy, cmd_done;
  logic [11:0] txt_addr;
  logic [7:0]  glyph_char;
  logic [3:0]  glyph_dy, glyph_fg, glyph_bg;
  logic [9:0]  fb_x, fb_y;

  string_scheduler dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_fg(cmd_fg), .cmd_bg(cmd_bg), .txt_rd_en(txt_rd_en), .txt_addr(txt_addr),
    .txt_rd_data(txt_rd_data), .glyph_start(glyph_start), .glyph_char(glyph_char),
    .glyph_dy(glyph_dy), .glyph_fg(glyph_fg), .glyph_bg(glyph_bg), .fb_x(fb_x), .fb_y(fb_y),
    .glyph_done(glyph_done), .busy(busy), .cmd_done(cmd_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [4096];
  always @(posedge clk) if (txt_rd_en) txt_rd_data <= mem[txt_addr];

  typedef struct packed {
    logic [7:0] ch; logic [3:0] dy; logic [9:0] fx; logic [9:0] fy;
    logic [3:0] fg; logic [3:0] bg; logic first;
  } job_t;

  job_t        exp_job[$];
  logic [11:0] exp_addr[$];
  bit          exp_done[$];   // 1: command renders nothing
  int errors = 0, checks = 0;
  int acc_cyc = 0, done_cyc = 0, cnt = 0, lat_fixed = 0, starts_seen = 0;
  bit spur_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {cmd_ready, busy, cmd_done, glyph_start, txt_rd_en, txt_addr, glyph_char,
                 glyph_dy, glyph_fg, glyph_bg, fb_x, fb_y}, RstExp);
  endtask

  // String-level reference: characters that fit, each expanded into GH row jobs.
  function automatic int push_cmd(input logic [11:0] b, input logic [7:0] l,
                                  input logic [9:0] x, input logic [9:0] y,
                                  input logic [3:0] f, input logic [3:0] g);
    int n = 0;
    while (n < int'(l) && (!Clip || int'(x) + n * GW + GW <= HRES)) n++;
    for (int k = 0; k < n; k++) begin
      logic [11:0] a;
      a = 12'(int'(b) + k);
      exp_addr.push_back(a);
      for (int d = 0; d < GH; d++) begin
        job_t j;
        j.ch = mem[a]; j.dy = 4'(d);
        j.fx = 10'(int'(x) + k * GW); j.fy = 10'(int'(y) + d);
        j.fg = f; j.bg = g; j.first = (k == 0 && d == 0);
        exp_job.push_back(j);
      end
    end
    exp_done.push_back(n == 0);
    return n;
  endfunction

  // Glyph unit: finishes each job after a latency; may pulse done spuriously when idle.
  initial forever begin
    @(posedge clk); #1;
    glyph_done = 1'b0;
    if (!reset_n) cnt = 0;
    else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin glyph_done = 1'b1; done_cyc = cyc; end
    end else if (spur_en && $urandom_range(0, 3) == 0) glyph_done = 1'b1;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a read, a job or a completion.
  initial begin : monitor
    logic [39:0] prev_f, cur_f, exp_f;
    job_t j;
    int exp_c;
    bit done_prev;
    prev_f = '0; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      cur_f = {glyph_char, glyph_dy, fb_x, fb_y, glyph_fg, glyph_bg};
      if (!reset_n) begin prev_f = cur_f; done_prev = 1'b0; continue; end
      if (done_prev) check("ready_after_done", cmd_ready, 1);
      done_prev = cmd_done;
      if (cmd_valid && cmd_ready) begin acc_cyc = cyc; starts_seen = 0; end
      if (txt_rd_en) begin
        if (exp_addr.size() == 0) fail("unexpected_read");
        else check("read_addr", txt_addr, exp_addr.pop_front());
      end
      if (!glyph_start) check("job_fields_stable", cur_f, prev_f);
      else if (exp_job.size() == 0) fail("unexpected_glyph_start");
      else begin
        j = exp_job.pop_front();
        exp_f = {j.ch, j.dy, j.fx, j.fy, j.fg, j.bg};
        check("job_fields", cur_f, exp_f);
        exp_c = j.first ? acc_cyc + 3 : (j.dy == 4'd0 ? done_cyc + 4 : done_cyc + 2);
        check("start_cycle", cyc, exp_c);
        starts_seen++;
        cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 10));
      end
      if (cmd_done) begin
        if (exp_done.size() == 0) fail("unexpected_cmd_done");
        else begin
          exp_c = exp_done.pop_front() ? acc_cyc + 1 : done_cyc + 1;
          check("done_cycle", cyc, exp_c);
          check("jobs_left_at_done", exp_job.size(), 0);
        end
      end
      prev_f = cur_f;
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy && exp_job.size() == 0 && exp_done.size() == 0 && exp_addr.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("timeout_waiting_idle");
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [11:0] b, input logic [7:0] l, input logic [9:0] x,
                      input logic [9:0] y, input logic [3:0] f, input logic [3:0] g);
    int n;
    bit ok = 1'b0;
    n = push_cmd(b, l, x, y, f, g);
    cmd_base = b; cmd_len = l; cmd_x = x; cmd_y = y; cmd_fg = f; cmd_bg = g;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready && reset_n) begin ok = 1'b1; break; end
    end
    if (!ok) fail("timeout_accept");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (n > 0) begin
      // A command offered while busy must be dropped, not queued.
      repeat (3) @(posedge clk);
      #1;
      cmd_base = 12'($urandom); cmd_len = 8'($urandom_range(1, 5)); cmd_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    int n;
    bit ok;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h100] = 8'h41;
    mem[12'h101] = 8'h42;

    // Reset held with a command pending: reset values, then accept on the first edge.
    cmd_base = 12'h100; cmd_len = 8'd2; cmd_x = 10'd16; cmd_y = 10'd4;
    cmd_fg = 4'hA; cmd_bg = 4'h5; cmd_valid = 1'b1;
    repeat (3) begin @(negedge clk); check_reset_vals("reset_values"); end
    n = push_cmd(12'h100, 8'd2, 10'd16, 10'd4, 4'hA, 4'h5);
    lat_fixed = 9;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle();

    send(12'h200, 8'd0, 10'd50, 10'd60, 4'h1, 4'h2);
    wait_idle();
    send(12'h300, 8'd4, 10'd304, 10'd100, 4'h3, 4'h4);
    wait_idle();
    send(12'hFFE, 8'd3, 10'd1016, 10'd1020, 4'hF, 4'h0);
    wait_idle();

    // Reset during WAIT_DONE of character 1, row 5.
    lat_fixed = 5;
    send(12'h7F0, 8'd3, 10'd0, 10'd8, 4'h6, 4'h7);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (starts_seen >= GH + 6) begin ok = 1'b1; break; end
    end
    if (!ok) fail("timeout_mid_command");
    @(posedge clk); #3;
    reset_n = 1'b0;
    exp_job.delete(); exp_addr.delete(); exp_done.delete();
    cnt = 0;
    #1;
    check_reset_vals("async_reset_values");
    repeat (3) begin @(negedge clk); check_reset_vals("reset_hold_values"); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(12'h050, 8'd2, 10'd40, 10'd30, 4'h9, 4'h8);
    wait_idle();

    lat_fixed = 0;
    for (int t = 0; t < 12; t++) begin
      logic [9:0] x;
      x = (t % 2 == 0) ? 10'($urandom) : 10'($urandom_range(0, 330));
      send((t % 4 == 0) ? 12'hFFD : 12'($urandom), 8'($urandom_range(0, 5)), x,
           10'($urandom), 4'($urandom), 4'($urandom));
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
